ahb_apb_bridge_mp: RTL and testbench
====================================

# ahb_apb_bridge_mp

Parametrised AHB-Lite to APB4 bridge serving `NUM_SLV` APB slaves, with a one-hot PSEL decoded from the upper address bits. It sits behind an AHB slave port and adds three things to a basic bridge:
- registered write data;
- a 2-cycle ERROR response for accesses to unmapped slave indices, without starting any APB transfer;
- a programmable PREADY timeout that aborts a hung APB transfer with ERROR.

## Interface
Parameters:
- `NUM_SLV`, 4: number of APB slaves, range 1..16.
- `SEL_W`, 4: width of the slave-index field; requires 2^SEL_W >= NUM_SLV.
- `PADDR_W`, 12: APB address width. `HADDR_W` = `PADDR_W` + `SEL_W` (derived).
- `TIMEOUT`, 256: maximum ACCESS cycles before abort; 0 disables the timeout.
- `PPROT_NS`, 1: constant driven on `pprot[1]`.

Ports:
- `hclk` in 1: clock; all logic is on the rising edge.
- `hreset` in 1: synchronous, active-high reset.
- `hsel`, `hready`, `hwrite` in 1; `htrans` in 2; `hsize` in 3; `hprot` in 4: AHB-Lite control.
- `haddr` in `HADDR_W`: AHB address.
- `hwdata` in 32: AHB write data.
- `hreadyout` out 1, `hresp` out 1, `hrdata` out 32: AHB response.
- `paddr` out `PADDR_W`; `psel` out `NUM_SLV`; `penable`, `pwrite` out 1; `pprot` out 3; `pstrb` out 4; `pwdata` out 32: APB request.
- `prdata` in `NUM_SLV`*32: slave k occupies bits [32k+31:32k].
- `pready`, `pslverr` in `NUM_SLV`: per-slave APB response.

## Operation
- Accept condition: `acc = hsel & htrans[1] & hready`. Slave index is `idx = haddr[PADDR_W +: SEL_W]`; the index is mapped when `idx < NUM_SLV`.
- Registers loaded on `acc`:
  - `paddr` <= {haddr[PADDR_W-1:2], 2'b00}
  - `pwrite` <= hwrite
  - `pprot` <= {~hprot[0], PPROT_NS, hprot[1]}
  - slave-select register <= one-hot(idx)
  - `pstrb`: reads give 0000. Writes by hsize: byte gives 1 << haddr[1:0]; half gives haddr[1] ? 1100 : 0011; word or larger gives 1111.
- Outputs: `psel` = select register & (state ∈ {SETUP, ACCESS}). `penable` = (state == ACCESS).
- The `prdata`, `pready` and `pslverr` muxes are AND-OR over the select register.
- States and transitions:
  - IDLE (`hreadyout`=1, `hresp`=0): `acc` & unmapped → ERR1; `acc` & write → WDATA; `acc` & read → SETUP; otherwise stay.
  - WDATA (`hreadyout`=0): `pwdata` <= hwdata; → SETUP.
  - SETUP (`hreadyout`=0): timeout counter cleared; → ACCESS.
  - ACCESS (`hreadyout`=0):
    - `pready` & ~`pslverr` → OKAY.
    - `pready` & `pslverr` → ERR1.
    - ~`pready` & counter == TIMEOUT-1 (when TIMEOUT > 0) → ERR1. This is an abort: `psel`/`penable` drop the next cycle.
    - Otherwise stay and increment the counter.
    - `pready` wins over a timeout in the same cycle.
  - OKAY (`hreadyout`=1, `hresp`=0): same transitions as IDLE.
  - ERR1 (`hreadyout`=0, `hresp`=1): → ERR2.
  - ERR2 (`hreadyout`=1, `hresp`=1): same transitions as IDLE. A master may pipeline a new transfer here and it is accepted.
- `hrdata` register:
  - Loaded with the muxed `prdata` when ACCESS & `pready` on a read, whether the response is OKAY or ERROR.
  - Loaded with 0 on a read that times out or hits an unmapped index.
  - Otherwise holds its value.
- `pwdata` holds its value between writes.
- `hresp` is 1 only in ERR1/ERR2.

## Timing
- All outputs after reset: `hreadyout`=1; `hresp`=0; `psel`=0; `penable`=0; `pwrite`=0; `paddr`=0; `pprot`=0; `pstrb`=0; `pwdata`=0; `hrdata`=0. State = IDLE, counter = 0.
- Read, zero wait states, address phase at T0: SETUP T1, ACCESS T2, OKAY T3. `hrdata` is valid and `hreadyout`=1 at T3. Latency is 3 cycles.
- Write, zero wait states, address phase at T0: WDATA T1 (`hwdata` sampled), SETUP T2, ACCESS T3, OKAY T4. Latency is 4 cycles.
- Each APB wait cycle (`pready`=0 in ACCESS) adds 1 cycle.
- Unmapped access at T0: ERR1 T1, ERR2 T2. No `psel` is asserted.
- Timeout at T0: first ACCESS cycle Ta; ERR1 at Ta+TIMEOUT, ERR2 at Ta+TIMEOUT+1.
- Back-to-back: an `acc` seen in OKAY or ERR2 goes straight to SETUP/WDATA with no IDLE cycle.
- `hreset` asserted in any state: at the next edge the state is IDLE and every output holds its reset value. This applies mid-ACCESS too; the APB transfer is abandoned and `psel` drops.
- `pwdata` and the APB control outputs are stable throughout SETUP and ACCESS.

## Test plan
- Read from slave 2, `haddr`=0x2_0A4, `pready`=1, `prdata2`=0xCAFE_F00D:
  - `psel`=0100 in T1..T2, `penable`=1 in T2, `paddr`=0x0A4.
  - At T3: `hrdata`=0xCAFE_F00D, `hreadyout`=1, `hresp`=0.
- Byte write to `haddr`=0x1_003, `hwdata`=0x5A00_0000, `pready` low for 3 cycles:
  - `pstrb`=1000 and `pwdata`=0x5A00_0000 from T2.
  - `hreadyout`=1 at T7.
- `pslverr1`=1 with `pready`=1: `hresp`=1 for 2 cycles, with `hreadyout` 0 then 1.
- Access to index 5 with NUM_SLV=4: `psel`=0 throughout, `hresp`=1 for 2 cycles, `hrdata`=0.
- TIMEOUT=4, `pready` held 0: ERR1 after 4 ACCESS cycles, then `psel`=0.
  - Repeat with `pready`=1 on the 4th ACCESS cycle: the required response is OKAY.
- Two reads issued back-to-back with the second accepted in OKAY: there is no IDLE cycle between them.
  - Assert `hreset` during the second ACCESS: next cycle all outputs are at reset values.

Source files
------------

// File: rtl/ahb_apb_bridge_mp.sv
`timescale 1ns/1ps
// AHB-Lite to APB4 bridge for NUM_SLV slaves: one-hot PSEL from the upper address bits,
// registered write data, ERROR on unmapped slave index and on a PREADY timeout.
module ahb_apb_bridge_mp #(
    parameter int NUM_SLV  = 4,
    parameter int SEL_W    = 4,
    parameter int PADDR_W  = 12,
    parameter int HADDR_W  = PADDR_W + SEL_W,
    parameter int TIMEOUT  = 256,
    parameter bit PPROT_NS = 1'b1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [3:0]            hprot,
    input  logic [HADDR_W-1:0]    haddr,
    input  logic [31:0]           hwdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [PADDR_W-1:0]    paddr,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [2:0]            pprot,
    output logic [3:0]            pstrb,
    output logic [31:0]           pwdata,
    input  logic [NUM_SLV*32-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    input  logic [NUM_SLV-1:0]    pslverr
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_OKAY, S_ERR1, S_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PADDR_W-1:0] paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [2:0]         pprot_q, pprot_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic [31:0]        hrdata_q, hrdata_d;

    logic               acc;
    logic [SEL_W-1:0]   idx;
    logic               mapped;
    logic [NUM_SLV-1:0] idx_onehot;
    logic [31:0]        prdata_masked [NUM_SLV];
    logic [31:0]        prdata_mux;
    logic               pready_mux;
    logic               pslverr_mux;
    logic [3:0]         strb_wr;
    logic               unused_ok;

    assign unused_ok = &{1'b0, hprot[3:2], htrans[0]};

    assign acc    = hsel & htrans[1] & hready;
    assign idx    = haddr[PADDR_W +: SEL_W];
    assign mapped = ({1'b0, idx} < (SEL_W + 1)'(NUM_SLV));

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign idx_onehot[gi]    = (idx == SEL_W'(gi));
            assign prdata_masked[gi] = prdata[32*gi +: 32] & {32{sel_q[gi]}};
        end
    endgenerate

    always_comb begin
        prdata_mux = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            prdata_mux = prdata_mux | prdata_masked[k];
        end
    end

    assign pready_mux  = |(pready & sel_q);
    assign pslverr_mux = |(pslverr & sel_q);

    always_comb begin
        case (hsize)
            3'd0:    strb_wr = 4'b0001 << haddr[1:0];
            3'd1:    strb_wr = haddr[1] ? 4'b1100 : 4'b0011;
            default: strb_wr = 4'b1111;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pprot_d  = pprot_q;
        pstrb_d  = pstrb_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        case (state_q)
            // Response-complete states double as address-phase accept points.
            S_IDLE, S_OKAY, S_ERR2: begin
                state_d = S_IDLE;
                if (acc) begin
                    paddr_d  = {haddr[PADDR_W-1:2], 2'b00};
                    pwrite_d = hwrite;
                    pprot_d  = {~hprot[0], PPROT_NS, hprot[1]};
                    sel_d    = idx_onehot;
                    pstrb_d  = hwrite ? strb_wr : 4'b0000;
                    if (!mapped) begin
                        state_d = S_ERR1;
                        if (!hwrite) hrdata_d = '0;
                    end else if (hwrite) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_WDATA: begin
                pwdata_d = hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready_mux) begin
                    if (!pwrite_q) hrdata_d = prdata_mux;
                    state_d = pslverr_mux ? S_ERR1 : S_OKAY;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    if (!pwrite_q) hrdata_d = '0;
                    state_d = S_ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pprot_q  <= '0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pprot_q  <= pprot_d;
            pstrb_q  <= pstrb_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign hreadyout = (state_q == S_IDLE) || (state_q == S_OKAY) || (state_q == S_ERR2);
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign psel      = sel_q & {NUM_SLV{(state_q == S_SETUP) || (state_q == S_ACCESS)}};
    assign penable   = (state_q == S_ACCESS);
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pprot     = pprot_q;
    assign pstrb     = pstrb_q;
    assign pwdata    = pwdata_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
`timescale 1ns/1ps
// Directed and randomised transfers through ahb_apb_bridge_mp (TIMEOUT=4), each checked
// against a transaction-level model of latency, response, data and APB request fields.
module tb_ahb_apb_bridge_mp;
    localparam int NS  = 4;
    localparam int TMO = 4;

    logic          hclk = 1'b0;
    logic          hreset = 1'b1;
    logic          hsel = 1'b0, hready = 1'b1, hwrite = 1'b0;
    logic [1:0]    htrans = 2'b00;
    logic [2:0]    hsize = 3'd0;
    logic [3:0]    hprot = 4'd0;
    logic [15:0]   haddr = 16'd0;
    logic [31:0]   hwdata = 32'd0;
    logic          hreadyout, hresp;
    logic [31:0]   hrdata;
    logic [11:0]   paddr;
    logic [NS-1:0] psel;
    logic          penable, pwrite;
    logic [2:0]    pprot;
    logic [3:0]    pstrb;
    logic [31:0]   pwdata;
    logic [NS*32-1:0] prdata = '0;
    logic [NS-1:0] pready = '0, pslverr = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hrdata = 32'd0;
    logic [31:0] m_pwdata = 32'd0;

    ahb_apb_bridge_mp #(.NUM_SLV(NS), .SEL_W(4), .PADDR_W(12), .TIMEOUT(TMO), .PPROT_NS(1'b1)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hprot(hprot), .haddr(haddr), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pprot(pprot), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, hreadyout, 1);
        check({tag, "_hresp"}, hresp, 0);
        check({tag, "_psel"}, psel, 0);
        check({tag, "_penable"}, penable, 0);
        check({tag, "_pwrite"}, pwrite, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pprot"}, pprot, 0);
        check({tag, "_pstrb"}, pstrb, 0);
        check({tag, "_pwdata"}, pwdata, 0);
        check({tag, "_hrdata"}, hrdata, 0);
    endtask

    // Called at a negedge; the address phase is driven immediately so that a call made
    // right after a completed transfer is issued back-to-back.
    task automatic xfer(input int idx, input logic wr, input logic [2:0] sz, input logic [11:0] off,
                        input logic [3:0] prot, input int waits, input logic err,
                        input logic [31:0] tdata, input logic [31:0] wd);
        bit mapped, tmo, exp_err;
        int n_access, exp_lat, lat, acc_seen, psel_cyc, pen_cyc, bad;
        logic [3:0] exp_strb;
        logic [2:0] exp_prot;
        logic [NS-1:0] exp_sel;
        logic prev_hresp;
        mapped   = (idx < NS);
        tmo      = mapped && (waits >= TMO);
        exp_err  = !mapped || tmo || err;
        n_access = !mapped ? 0 : (tmo ? TMO : waits + 1);
        exp_lat  = !mapped ? 2 : (wr ? 1 : 0) + 1 + n_access + (exp_err ? 2 : 1);
        exp_sel  = mapped ? (NS'(1) << idx) : '0;
        exp_prot = {~prot[0], 1'b1, prot[1]};
        if (!wr)            exp_strb = 4'b0000;
        else if (sz == 3'd0) exp_strb = 4'b0001 << off[1:0];
        else if (sz == 3'd1) exp_strb = off[1] ? 4'b1100 : 4'b0011;
        else                 exp_strb = 4'b1111;
        for (int k = 0; k < NS; k++) prdata[32*k +: 32] = $urandom;
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
        if (mapped) begin
            prdata[32*idx +: 32] = tdata;
            pready[idx]  = 1'b0;
            pslverr[idx] = err;
        end
        hsel = 1'b1; htrans = 2'b10; hready = 1'b1; hwrite = wr; hsize = sz; hprot = prot;
        haddr = {idx[3:0], off};
        @(posedge hclk);
        lat = 0; acc_seen = 0; psel_cyc = 0; pen_cyc = 0; bad = 0; prev_hresp = 1'bx;
        for (int c = 0; c < 40; c++) begin
            @(negedge hclk);
            lat++;
            hsel = 1'b0; htrans = 2'b00; hwdata = wd;
            if (psel != '0) begin
                psel_cyc++;
                if (psel !== exp_sel || paddr !== {off[11:2], 2'b00} || pwrite !== wr ||
                    pstrb !== exp_strb || pprot !== exp_prot || (wr && pwdata !== wd)) bad++;
            end
            if (penable === 1'b1) begin
                pen_cyc++;
                if (mapped) pready[idx] = (acc_seen == waits);
                acc_seen++;
            end else if (mapped) begin
                pready[idx] = 1'b0;
            end
            if (hreadyout === 1'b1) break;
            prev_hresp = hresp;
        end
        if (!wr) m_hrdata = (mapped && !tmo) ? tdata : 32'd0;
        if (wr && mapped) m_pwdata = wd;
        check("latency", lat, exp_lat);
        check("hresp_final", hresp, exp_err);
        check("hresp_prev", prev_hresp, exp_err);
        check("hrdata", hrdata, m_hrdata);
        check("pwdata", pwdata, m_pwdata);
        check("psel_cycles", psel_cyc, mapped ? 1 + n_access : 0);
        check("penable_cycles", pen_cyc, n_access);
        check("apb_ctrl", bad, 0);
        $display("xfer idx=%0d wr=%0d sz=%0d off=%03h waits=%0d err=%0d lat=%0d hresp=%0d hrdata=%08h",
                 idx, wr, sz, off, waits, err, lat, hresp, hrdata);
    endtask

    task automatic idle_gap();
        @(negedge hclk);
        check("idle_hreadyout", hreadyout, 1);
        check("idle_hresp", hresp, 0);
    endtask

    initial begin
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check_reset_outputs("reset");
        hreset = 1'b0;

        // Read slave 2, zero wait states.
        xfer(2, 1'b0, 3'd2, 12'h0A4, 4'h3, 0, 1'b0, 32'hCAFE_F00D, 32'h0);
        check("rd2_hrdata", hrdata, 32'hCAFE_F00D);
        idle_gap();
        // Byte write to lane 3, three APB wait cycles.
        xfer(1, 1'b1, 3'd0, 12'h003, 4'h0, 3, 1'b0, 32'h0, 32'h5A00_0000);
        check("wr1_pwdata", pwdata, 32'h5A00_0000);
        idle_gap();
        // Slave error on slave 1.
        xfer(1, 1'b0, 3'd2, 12'h010, 4'h1, 0, 1'b1, 32'h1234_5678, 32'h0);
        idle_gap();
        // Unmapped index 5.
        xfer(5, 1'b0, 3'd2, 12'h020, 4'h1, 0, 1'b0, 32'h0, 32'h0);
        check("unmapped_hrdata", hrdata, 32'h0);
        idle_gap();
        // Hung slave: timeout, then pready just in time on the last allowed cycle.
        xfer(0, 1'b0, 3'd2, 12'h030, 4'h1, 100, 1'b0, 32'hDEAD_BEEF, 32'h0);
        xfer(3, 1'b0, 3'd2, 12'h034, 4'h1, TMO - 1, 1'b0, 32'hBEEF_0001, 32'h0);
        idle_gap();

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 5);
            xfer($urandom_range(0, 5), 1'($urandom), 3'($urandom_range(0, 3)), 12'($urandom),
                 4'($urandom), (r == 5) ? 100 : ((r == 4) ? TMO - 1 : r),
                 ($urandom_range(0, 3) == 0), $urandom, $urandom);
            if ($urandom_range(0, 1) == 0) idle_gap();
        end

        // Back-to-back reads, second one abandoned by reset in its ACCESS phase.
        xfer(0, 1'b0, 3'd2, 12'h010, 4'h1, 0, 1'b0, 32'h1111_2222, 32'h0);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 16'h3_040;
        pready = '0;
        @(posedge hclk);
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b00;
        check("b2b_setup_psel", psel, 4'b1000);
        check("b2b_setup_hreadyout", hreadyout, 0);
        @(negedge hclk);
        check("b2b_access_penable", penable, 1);
        hreset = 1'b1;
        @(negedge hclk);
        check_reset_outputs("midreset");
        hreset = 1'b0;
        m_hrdata = 32'd0;
        m_pwdata = 32'd0;
        idle_gap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
